scheduler_req_buffer: RTL



---
 rtl/scheduler_req_buffer_pkg.sv | 15 +
 rtl/scheduler_req_fifo.sv | 119 +++++++++++
 rtl/scheduler_req_buffer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/scheduler_req_buffer_pkg.sv
// Shared types and defaults for the DRAM scheduler request buffer.
// Optional feature macro: SCHED_FWD_EN (store-to-load forwarding).
package dram_pack;

    localparam int SCHED_WORD_W        = 32;
    localparam int SCHED_DEPTH_DEFAULT = 8;

    // One buffered memory request as seen by the scheduler
    typedef struct packed {
        logic [SCHED_WORD_W-1:0] addr;
        logic [SCHED_WORD_W-1:0] data;
        logic                    wen;
    } sched_req_t;

endpackage

// File: rtl/scheduler_req_fifo.sv
// In-order request storage with head and head+1 read ports.
// Optional feature macro: SCHED_FWD_EN adds an age-ordered view of all slots
// so the parent can search buffered writes.
module scheduler_req_fifo
    import dram_pack::*;
#(
    parameter int WORD_W = SCHED_WORD_W,
    parameter int DEPTH  = SCHED_DEPTH_DEFAULT,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] pushAddr_i,
    input  logic [WORD_W-1:0] pushData_i,
    input  logic              pushWen_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              headValid_o,
    output logic [WORD_W-1:0] headAddr_o,
    output logic [WORD_W-1:0] headData_o,
    output logic              headWen_o,
    output logic              ftValid_o,
    output logic [WORD_W-1:0] ftAddr_o,
    output logic [WORD_W-1:0] ftData_o,
    output logic              ftWen_o
`ifdef SCHED_FWD_EN
    ,
    output logic [DEPTH-1:0]             ordValid_o,
    output logic [DEPTH-1:0][WORD_W-1:0] ordAddr_o,
    output logic [DEPTH-1:0][WORD_W-1:0] ordData_o,
    output logic [DEPTH-1:0]             ordWen_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              wen;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] ftIdx;
    entry_t           headEntry;
    entry_t           ftEntry;

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap for free
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop_i) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; count alone tells full from empty
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot storage needs no reset because every read is masked by occupancy
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[tail_q] <= '{addr: pushAddr_i, data: pushData_i, wen: pushWen_i};
        end
    end

    // Head and lookahead read ports, zeroed when the slot holds nothing
    always_comb begin
        ftIdx       = head_q + PTR_W'(1);
        headEntry   = mem_q[head_q];
        ftEntry     = mem_q[ftIdx];
        headValid_o = (count_q != '0);
        ftValid_o   = (count_q >= CNT_W'(2));
        headAddr_o  = headValid_o ? headEntry.addr : '0;
        headData_o  = headValid_o ? headEntry.data : '0;
        headWen_o   = headValid_o ? headEntry.wen  : 1'b0;
        ftAddr_o    = ftValid_o   ? ftEntry.addr   : '0;
        ftData_o    = ftValid_o   ? ftEntry.data   : '0;
        ftWen_o     = ftValid_o   ? ftEntry.wen    : 1'b0;
    end

    assign count_o = count_q;

`ifdef SCHED_FWD_EN
    // Age-ordered view: position 0 is the oldest entry, higher positions are younger
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ordValid_o[i] = (CNT_W'(i) < count_q);
            ordAddr_o[i]  = mem_q[head_q + PTR_W'(i)].addr;
            ordData_o[i]  = mem_q[head_q + PTR_W'(i)].data;
            ordWen_o[i]   = mem_q[head_q + PTR_W'(i)].wen;
        end
    end
`endif

endmodule

// File: rtl/scheduler_req_buffer.sv
// Request queue between the cache memory port and the DRAM command scheduler.
// Adds accept/retire control, protocol error pulse and the retire callback
// around scheduler_req_fifo.
// Optional feature macro: SCHED_FWD_EN (reads hitting a buffered write are
// answered from the buffer and never enqueued).
module scheduler_req_buffer
    import dram_pack::*;
#(
    parameter int WORD_W = SCHED_WORD_W,
    parameter int DEPTH  = SCHED_DEPTH_DEFAULT,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] memaddr,
    input  logic [WORD_W-1:0] memstore,
    output logic              dwait,
    input  logic              request_done,
    output logic              rq_valid,
    output logic [WORD_W-1:0] ramaddr_rq,
    output logic [WORD_W-1:0] ramstore_rq,
    output logic              ramwen_rq,
    output logic              ft_valid,
    output logic [WORD_W-1:0] ramaddr_rq_ft,
    output logic [WORD_W-1:0] ramstore_rq_ft,
    output logic              ramwen_rq_ft,
    output logic              callback_valid,
    output logic [WORD_W-1:0] memaddr_callback,
    output logic              callback_wen,
    output logic [CNT_W-1:0]  count,
    output logic              err
`ifdef SCHED_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [WORD_W-1:0] fwd_data
`endif
);

    logic              reqPresent;
    logic              bothReq;
    logic              isFull;
    logic              fwdTake;
    logic              pushEn;
    logic              popEn;
    logic [WORD_W-1:0] pushData;

    logic              callbackValid_q, callbackValid_d;
    logic [WORD_W-1:0] callbackAddr_q, callbackAddr_d;
    logic              callbackWen_q, callbackWen_d;
    logic              err_q, err_d;

`ifdef SCHED_FWD_EN
    logic [DEPTH-1:0]             ordValid;
    logic [DEPTH-1:0][WORD_W-1:0] ordAddr;
    logic [DEPTH-1:0][WORD_W-1:0] ordData;
    logic [DEPTH-1:0]             ordWen;
    logic                         fwdHit;
    logic [WORD_W-1:0]            fwdHitData;
    logic                         fwdValid_q, fwdValid_d;
    logic [WORD_W-1:0]            fwdData_q, fwdData_d;
`endif

    scheduler_req_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (pushEn),
        .pushAddr_i  (memaddr),
        .pushData_i  (pushData),
        .pushWen_i   (dWEN),
        .pop_i       (popEn),
        .count_o     (count),
        .headValid_o (rq_valid),
        .headAddr_o  (ramaddr_rq),
        .headData_o  (ramstore_rq),
        .headWen_o   (ramwen_rq),
        .ftValid_o   (ft_valid),
        .ftAddr_o    (ramaddr_rq_ft),
        .ftData_o    (ramstore_rq_ft),
        .ftWen_o     (ramwen_rq_ft)
`ifdef SCHED_FWD_EN
        ,
        .ordValid_o  (ordValid),
        .ordAddr_o   (ordAddr),
        .ordData_o   (ordData),
        .ordWen_o    (ordWen)
`endif
    );

`ifdef SCHED_FWD_EN
    // Youngest buffered write to the read address wins, so later positions override earlier ones
    always_comb begin
        fwdHit     = 1'b0;
        fwdHitData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ordValid[i] && ordWen[i] && (ordAddr[i] == memaddr)) begin
                fwdHit     = 1'b1;
                fwdHitData = ordData[i];
            end
        end
        fwdTake = dREN && !dWEN && fwdHit;
    end
`else
    assign fwdTake = 1'b0;
`endif

    // Accept/retire decisions; a full buffer never accepts, even when the head retires this cycle
    always_comb begin
        reqPresent = dREN | dWEN;
        bothReq    = dREN & dWEN;
        isFull     = (count == CNT_W'(DEPTH));
        dwait      = reqPresent && isFull && !fwdTake;
        pushEn     = reqPresent && !isFull && !fwdTake;
        popEn      = request_done && rq_valid;
        pushData   = dWEN ? memstore : '0;
    end

    // Next values of the callback, error and forwarding pulses
    always_comb begin
        callbackValid_d = popEn;
        callbackAddr_d  = popEn ? ramaddr_rq : '0;
        callbackWen_d   = popEn ? ramwen_rq  : 1'b0;
        err_d           = bothReq || (request_done && !rq_valid);
`ifdef SCHED_FWD_EN
        fwdValid_d      = fwdTake;
        fwdData_d       = fwdTake ? fwdHitData : '0;
`endif
    end

    // One-cycle pulse registers; reset discards any pending callback
    always_ff @(posedge CLK) begin
        if (RST) begin
            callbackValid_q <= 1'b0;
            callbackAddr_q  <= '0;
            callbackWen_q   <= 1'b0;
            err_q           <= 1'b0;
`ifdef SCHED_FWD_EN
            fwdValid_q      <= 1'b0;
            fwdData_q       <= '0;
`endif
        end else begin
            callbackValid_q <= callbackValid_d;
            callbackAddr_q  <= callbackAddr_d;
            callbackWen_q   <= callbackWen_d;
            err_q           <= err_d;
`ifdef SCHED_FWD_EN
            fwdValid_q      <= fwdValid_d;
            fwdData_q       <= fwdData_d;
`endif
        end
    end

    assign callback_valid   = callbackValid_q;
    assign memaddr_callback = callbackAddr_q;
    assign callback_wen     = callbackWen_q;
    assign err              = err_q;
`ifdef SCHED_FWD_EN
    assign fwd_valid        = fwdValid_q;
    assign fwd_data         = fwdData_q;
`endif

endmodule
